// File: rtl/uart_reg_bridge.sv
// Byte-command register bridge on the host side of a UART FIFO pair.
// Decodes write (0x57 addr data -> ACK 0x06) and read (0x52 addr -> value)
// commands, drives a simple register port, and pushes one response byte.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   rx_empty, r_data    : RX FIFO status and show-ahead head byte
//   rd_uart             : RX FIFO pop (combinational)
//   tx_full             : TX FIFO full
//   wr_uart, w_data     : TX FIFO push (combinational) and response byte
//   reg_wr_en/reg_rd_en : one-cycle register strobes
//   reg_addr/reg_wdata  : register address and write data
//   reg_rdata           : register read data, valid the cycle after reg_rd_en
//   busy                : command or response in progress
//   err_count           : saturating count of NAKs plus inter-byte timeouts
module uart_reg_bridge #(
  parameter int unsigned NREGS   = 16,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int unsigned      CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [8:0]       NREGS_LIM = 9'(NREGS);
  localparam logic [7:0]       OP_WR     = 8'h57;
  localparam logic [7:0]       OP_RD     = 8'h52;
  localparam logic [7:0]       ACK       = 8'h06;
  localparam logic [7:0]       NAK       = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_DO_WRITE, S_DO_READ, S_CAPTURE, S_SEND
  } state_t;

  state_t           state, state_next;
  logic             is_wr;
  logic [CNT_W-1:0] tmo_cnt;
  logic             in_get, pop, send_nak, send_ack, tmo_hit;
  logic             new_addr_ok, cur_addr_ok;

  // Popping is only allowed while collecting command bytes; the FIFO handshakes
  // are combinational so a byte can be consumed or pushed in the same cycle.
  assign in_get      = (state == S_GET_ADDR) || (state == S_GET_DATA);
  assign pop         = ((state == S_IDLE) || in_get) && !rx_empty;
  assign rd_uart     = pop && !reset;
  assign wr_uart     = (state == S_SEND) && !tx_full && !reset;
  assign new_addr_ok = {1'b0, r_data} < NREGS_LIM;
  assign cur_addr_ok = {1'b0, reg_addr} < NREGS_LIM;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and response selection
  always_comb begin
    state_next = state;
    send_nak   = 1'b0;
    send_ack   = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) begin
          if (r_data == OP_WR || r_data == OP_RD) begin
            state_next = S_GET_ADDR;
          end else begin
            state_next = S_SEND;
            send_nak   = 1'b1;
          end
        end
      end
      S_GET_ADDR: begin
        if (pop) begin
          if (is_wr) begin
            state_next = S_GET_DATA;
          end else if (new_addr_ok) begin
            state_next = S_DO_READ;
          end else begin
            state_next = S_SEND;
            send_nak   = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = S_IDLE;
          tmo_hit    = 1'b1;
        end
      end
      S_GET_DATA: begin
        if (pop) begin
          if (cur_addr_ok) begin
            state_next = S_DO_WRITE;
          end else begin
            state_next = S_SEND;
            send_nak   = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = S_IDLE;
          tmo_hit    = 1'b1;
        end
      end
      S_DO_WRITE: begin
        state_next = S_SEND;
        send_ack   = 1'b1;
      end
      S_DO_READ:  state_next = S_CAPTURE;
      S_CAPTURE:  state_next = S_SEND;
      S_SEND: begin
        if (!tx_full) state_next = S_IDLE;
      end
      default:    state_next = S_IDLE;
    endcase
  end

  // Registered outputs, command latches, timeout and error counters
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      busy      <= 1'b0;
      is_wr     <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      w_data    <= 8'h00;
      tmo_cnt   <= '0;
      err_count <= 8'h00;
    end else begin
      reg_wr_en <= (state_next == S_DO_WRITE);
      reg_rd_en <= (state_next == S_DO_READ);
      busy      <= (state_next != S_IDLE);
      if (pop && state == S_IDLE)     is_wr     <= (r_data == OP_WR);
      if (pop && state == S_GET_ADDR) reg_addr  <= r_data;
      if (pop && state == S_GET_DATA) reg_wdata <= r_data;
      if (send_nak)                w_data <= NAK;
      else if (send_ack)           w_data <= ACK;
      else if (state == S_CAPTURE) w_data <= reg_rdata;
      // Counts consecutive empty cycles while a command is partially received
      if (pop || !in_get || tmo_hit) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + CNT_W'(1);
      if ((send_nak || tmo_hit) && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-command register bridge sitting on the host side of `UART_Top`'s FIFO interface. It consumes received bytes (`rd_uart`/`r_data`/`rx_empty`), decodes read/write commands addressed to a small register bank, drives a simple register port, and pushes response bytes back (`wr_uart`/`w_data`/`tx_full`). It turns the serial link into a register-access channel for the rest of the design.

## Interface
Parameters:
- `NREGS`, 16: number of addressable registers; valid addresses are 0..NREGS-1, with NREGS ≤ 256.
- `TIMEOUT`, 100000: inter-byte timeout in `clk` cycles. It applies while waiting for the 2nd or 3rd byte of a command.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: system clock, the same clock as `UART_Top`.
- `reset`, in, 1: synchronous, active-high.
- `rx_empty`, in, 1: RX FIFO empty.
- `r_data`, in, 8: RX FIFO head byte. It is valid whenever `rx_empty`=0 (show-ahead).
- `rd_uart`, out, 1: RX FIFO pop, one cycle per byte.
- `tx_full`, in, 1: TX FIFO full.
- `wr_uart`, out, 1: TX FIFO push, one cycle per byte.
- `w_data`, out, 8: TX byte, valid when `wr_uart`=1.
- `reg_wr_en`, out, 1: register write strobe, one cycle.
- `reg_rd_en`, out, 1: register read strobe, one cycle.
- `reg_addr`, out, 8: register address.
- `reg_wdata`, out, 8: register write data.
- `reg_rdata`, in, 8: register read data, valid in the cycle after `reg_rd_en`.
- `busy`, out, 1: high when state ≠ IDLE.
- `err_count`, out, 8: saturating count of NAKs plus timeouts.

## Operation
Command format:
- Write: `0x57`, addr, data. Response is `0x06` (ACK).
- Read: `0x52`, addr. Response is one byte containing the register value.
- Any other first byte: respond `0x15` (NAK) and return to IDLE.
- Address ≥ NREGS: respond NAK. No `reg_wr_en`/`reg_rd_en` is issued. For a write, the data byte is still consumed before the NAK is sent.

FIFO rules:
- `rd_uart` is combinational: `rd_uart` = (state ∈ {IDLE, GET_ADDR, GET_DATA}) & ~`rx_empty`.
- The byte is captured from `r_data` on the same edge that pops it.
- Back-to-back pops on consecutive cycles are legal.
- `wr_uart` is asserted only in SEND with `tx_full`=0, for exactly one cycle.
- No byte is popped from the moment a command completes until its response has been pushed. Commands are never pipelined.

State machine:
- IDLE: on pop, `0x57` → GET_ADDR (write), `0x52` → GET_ADDR (read), other → SEND with NAK.
- GET_ADDR: on pop, latch `reg_addr`. Then:
  - write → GET_DATA
  - read with valid address → DO_READ
  - read with invalid address → SEND with NAK
- GET_DATA: on pop, latch `reg_wdata`. Valid address → DO_WRITE; invalid address → SEND with NAK.
- DO_WRITE: `reg_wr_en`=1 for one cycle → SEND with ACK.
- DO_READ: `reg_rd_en`=1 for one cycle → CAPTURE.
- CAPTURE: `w_data` ← `reg_rdata` → SEND.
- SEND: hold while `tx_full`=1. When `tx_full`=0, pulse `wr_uart` → IDLE.

Timeout:
- A counter clears on every pop and on entry to GET_ADDR/GET_DATA.
- It increments on each cycle spent in GET_ADDR/GET_DATA with `rx_empty`=1.
- When it reaches TIMEOUT−1: go to IDLE, increment `err_count`, send no response, discard the partial command.

Errors:
- `err_count` increments on each NAK at SEND entry and on each timeout.
- It saturates at 255 and never wraps.

## Timing
- Reset: state=IDLE; all strobes (`rd_uart` aside) = 0; `w_data`=0, `reg_addr`=0, `reg_wdata`=0, `busy`=0, `err_count`=0; timeout counter=0.
- `rd_uart` is 0 during reset regardless of `rx_empty`.
- Reset mid-command or mid-SEND drops everything: no pending strobe or push survives.
- Write latency: last byte popped at edge N → `reg_wr_en` high in cycle N+1 → `wr_uart`(`0x06`) in cycle N+2 if `tx_full`=0.
- Read latency: addr popped at edge N → `reg_rd_en` in N+1 → CAPTURE in N+2 → `wr_uart` in N+3.
- NAK latency: the offending byte popped at edge N → `wr_uart`(`0x15`) in N+1 if `tx_full`=0.
- `tx_full` stuck high: the bridge stays in SEND indefinitely. `w_data` is stable, `wr_uart`=0, no pops, no timeout.
- The next command's first byte can be popped in the cycle after `wr_uart`.

## Test plan
- Write then read back: FIFO bytes `57 03 A5`, then `52 03` → one `reg_wr_en` with addr=3, wdata=`A5`. TX bytes are `06`, then `A5` (register model returns the written value). `err_count`=0.
- Back-to-back bytes: all five bytes present at once (`rx_empty`=0 throughout) → pops occur on consecutive cycles within each command. No pop occurs between the first command's completion and its `wr_uart`. Cycle latencies match the Timing section exactly.
- Bad opcode / bad address: bytes `3C` → TX `15`. Bytes `57 10 FF` with NREGS=16 → no `reg_wr_en`, TX `15`, 3 bytes consumed. `err_count`=2.
- Timeout: byte `52` then silence for TIMEOUT cycles → return to IDLE, no TX byte, `err_count`+1. A following `52 00` is handled normally.
- TX backpressure: hold `tx_full`=1 for 50 cycles during a read response → `wr_uart`=0 and `rd_uart`=0 throughout. The single push of the correct byte occurs on the first cycle with `tx_full`=0.
- Reset mid-command: after `57 05`, assert `reset` for 1 cycle, then send `52 05` → no write ever issued. Response is the pre-reset register value. All outputs were at reset values in the cycle after reset.
